// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the register-file write port between the MEM/WB pipeline latch and
//   the multi-cycle multiply/divide unit (MDU). The pipeline always wins. An
//   MDU result is parked in a one-entry buffer and written on a cycle where
//   the pipeline does not write. If the buffer loses STARVE_LIMIT cycles in a
//   row, the arbiter stalls the pipeline for one cycle and drains the buffer.
//
// Parameters
//   STARVE_LIMIT   consecutive lost cycles before a forced stall (1..15)
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   pipe_regwrite  MEM/WB regwrite
//   pipe_write_reg MEM/WB destination register
//   pipe_wdata     MEM/WB writeback data
//   mdu_valid      MDU result valid
//   mdu_write_reg  MDU destination register
//   mdu_wdata      MDU result data
//   mdu_ready      buffer can accept an MDU result
//   stall_pipe     hold MEM/WB and all upstream stages this cycle
//   rf_we          register-file write enable (registered)
//   rf_waddr       register-file write address (registered)
//   rf_wdata       register-file write data (registered)
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_regwrite,
  input  logic [4:0]  pipe_write_reg,
  input  logic [31:0] pipe_wdata,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_write_reg,
  input  logic [31:0] mdu_wdata,
  output logic        mdu_ready,
  output logic        stall_pipe,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FORCE = 2'd2
  } state_t;

  localparam logic [4:0] LIMIT = 5'(STARVE_LIMIT);

  state_t      state_reg;
  logic [3:0]  wait_cnt_reg;
  logic [4:0]  buf_waddr_reg;
  logic [31:0] buf_wdata_reg;
  logic        rf_we_reg;
  logic [4:0]  rf_waddr_reg;
  logic [31:0] rf_wdata_reg;

  logic        pipe_req;
  logic        mdu_fire;
  logic [4:0]  wait_inc;

  // Writes to $0 are architecturally void, so they never count as a request.
  assign pipe_req = pipe_regwrite && (pipe_write_reg != 5'd0);
  assign mdu_fire = mdu_valid && mdu_ready;
  // One bit wider than the counter so the saturation check sees the carry.
  assign wait_inc = {1'b0, wait_cnt_reg} + 5'd1;

  assign mdu_ready  = (state_reg == IDLE) && !rst;
  assign stall_pipe = (state_reg == FORCE);
  assign rf_we      = rf_we_reg;
  assign rf_waddr   = rf_waddr_reg;
  assign rf_wdata   = rf_wdata_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= 4'd0;
      buf_waddr_reg <= 5'd0;
      buf_wdata_reg <= 32'd0;
      rf_we_reg     <= 1'b0;
      rf_waddr_reg  <= 5'd0;
      rf_wdata_reg  <= 32'd0;
    end else begin
      // Address/data hold their last value when nothing is written.
      rf_we_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pipe_req) begin
            rf_we_reg    <= 1'b1;
            rf_waddr_reg <= pipe_write_reg;
            rf_wdata_reg <= pipe_wdata;
          end
          // No bypass: a captured result is written at the earliest one
          // cycle later. A captured $0 result is simply dropped.
          if (mdu_fire && (mdu_write_reg != 5'd0)) begin
            buf_waddr_reg <= mdu_write_reg;
            buf_wdata_reg <= mdu_wdata;
            wait_cnt_reg  <= 4'd0;
            state_reg     <= HOLD;
          end
        end

        HOLD: begin
          if (!pipe_req) begin
            rf_we_reg    <= 1'b1;
            rf_waddr_reg <= buf_waddr_reg;
            rf_wdata_reg <= buf_wdata_reg;
            wait_cnt_reg <= 4'd0;
            state_reg    <= IDLE;
          end else begin
            rf_we_reg    <= 1'b1;
            rf_waddr_reg <= pipe_write_reg;
            rf_wdata_reg <= pipe_wdata;
            if (pipe_write_reg == buf_waddr_reg) begin
              // The pipeline value is younger; the buffered one is dead.
              wait_cnt_reg <= 4'd0;
              state_reg    <= IDLE;
            end else if (wait_inc >= LIMIT) begin
              wait_cnt_reg <= 4'd0;
              state_reg    <= FORCE;
            end else begin
              wait_cnt_reg <= wait_inc[4] ? 4'hF : wait_inc[3:0];
            end
          end
        end

        FORCE: begin
          // Pipeline is stalled this cycle and re-presents MEM/WB next cycle,
          // so its inputs are ignored here.
          rf_we_reg    <= 1'b1;
          rf_waddr_reg <= buf_waddr_reg;
          rf_wdata_reg <= buf_wdata_reg;
          wait_cnt_reg <= 4'd0;
          state_reg    <= IDLE;
        end

        default: begin
          wait_cnt_reg <= 4'd0;
          state_reg    <= IDLE;
        end
      endcase
    end
  end

endmodule
